// File: rtl/mskand_pkg.sv
// Shared definitions for the multi-lane HPC3 masked AND.
//   hpc3rnd(d)        random bits consumed per lane per beat
//   ROLE_PREV_*       encodings for the SWAP parameter (which operand is prev-staged)
//   sh_idx(s,l,w)     bit index of share s of lane l in a d*W share vector
//   pair_idx(i,j,n)   index of unordered share pair {i,j} among n shares
package mskand_pkg;

  localparam int ROLE_PREV_B = 0;  // b gates the mask terms, a is the current operand
  localparam int ROLE_PREV_A = 1;  // roles exchanged

  function automatic int hpc3rnd(input int n);
    return n * (n - 1);
  endfunction

  function automatic int sh_idx(input int s, input int l, input int w);
    return s * w + l;
  endfunction

  // Enumerates pairs (0,1),(0,2)..(0,n-1),(1,2).. so both orderings of a pair
  // share the same random bit.
  function automatic int pair_idx(input int i, input int j, input int n);
    int lo;
    int hi;
    int idx;
    lo  = (i < j) ? i : j;
    hi  = (i < j) ? j : i;
    idx = 0;
    for (int k = 0; k < lo; k++) idx += n - 1 - k;
    return idx + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/mskand_hpc3_lane.sv
// One HPC3 AND lane with d shares, including its output (S2) register.
//   clk, rst   clock, async active-high reset
//   load       capture the HPC3 terms computed from x, y, r
//   clr        clear all term registers (used only for zeroization)
//   x          prev-role operand shares (gates the mask terms)
//   y          current-role operand shares
//   r          lane randomness: low half r_ij, high half r'_ij, per unordered pair
//   z          output shares, XOR of the registered terms of each share domain
// Every term is registered on its own; recombination of the terms of one
// output share only happens after the register, so no glitchy combination of
// unmasked products can occur.
module mskand_hpc3_lane
  import mskand_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clr,
  input  logic [d-1:0]            x,
  input  logic [d-1:0]            y,
  input  logic [hpc3rnd(d)-1:0]   r,
  output logic [d-1:0]            z
);

  localparam int HALF = hpc3rnd(d) / 2;

  // [i][j]: i = output share domain, j = partner share.
  // Diagonal of mul holds x_i*y_i; diagonal of msk is unused and stays 0.
  logic [d-1:0][d-1:0] mul_d, mul_q;
  logic [d-1:0][d-1:0] msk_d, msk_q;

  for (genvar i = 0; i < d; i++) begin : g_i
    for (genvar j = 0; j < d; j++) begin : g_j
      if (i == j) begin : g_diag
        assign mul_d[i][j] = x[i] & y[i];
        assign msk_d[i][j] = 1'b0;
      end else begin : g_cross
        localparam int P = pair_idx(i, j, d);
        // x_i(y_j ^ r_ij) and (!x_i & r_ij) ^ r'_ij: the r terms sum to
        // r_ij ^ r'_ij per domain, which cancels over the symmetric pair.
        assign mul_d[i][j] = x[i] & (y[j] ^ r[P]);
        assign msk_d[i][j] = (~x[i] & r[P]) ^ r[HALF + P];
      end
    end
    assign z[i] = (^mul_q[i]) ^ (^msk_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_q <= '0;
      msk_q <= '0;
    end else if (load) begin
      mul_q <= mul_d;
      msk_q <= msk_d;
    end else if (clr) begin
      mul_q <= '0;
      msk_q <= '0;
    end
  end

endmodule

// File: rtl/mskand_hpc3_lanes.sv
// W-lane masked AND built from HPC3 gadgets, d shares per lane, two-stage
// pipeline (S1 staging, S2 HPC3 output register) with valid/ready flow control.
//   clk, rst             clock, async active-high reset
//   in_a, in_b           operand sharings, share s of lane l at bit s*W+l
//   in_valid / in_ready  operand handshake (accept also needs rnd_valid)
//   rnd / rnd_valid      fresh randomness, lane l at [l*hpc3rnd(d) +: hpc3rnd(d)]
//   rnd_ready            randomness consumed this cycle (equals accept)
//   out                  sharing of a&b, same layout as inputs
//   out_valid/out_ready  result handshake
// Parameters: d shares, W lanes, SWAP selects which operand is prev-staged.
// Build option: MSKAND_LANES_ZEROIZE_EN forces out to zero while out_valid is
// low and clears S1/S2 share registers on a pop not replaced by a new beat.
module mskand_hpc3_lanes
  import mskand_pkg::*;
#(
  parameter int d    = 2,
  parameter int W    = 8,
  parameter int SWAP = ROLE_PREV_B
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [d*W-1:0]          in_a,
  input  logic [d*W-1:0]          in_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W*hpc3rnd(d)-1:0] rnd,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  output logic [d*W-1:0]          out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int RL = hpc3rnd(d);

  logic                s1_valid;
  logic [d*W-1:0]      s1_prev;
  logic [d*W-1:0]      s1_cur;
  logic [W*RL-1:0]     s1_rnd;

  logic                s2_move;
  logic                s1_move;
  logic                fire;
  logic                s2_load;
  logic                s2_clr;
  logic [d*W-1:0]      prev_in;
  logic [d*W-1:0]      cur_in;
  logic [d*W-1:0]      out_raw;

  assign prev_in = (SWAP == ROLE_PREV_A) ? in_a : in_b;
  assign cur_in  = (SWAP == ROLE_PREV_A) ? in_b : in_a;

  assign s2_move   = !out_valid || out_ready;
  assign s1_move   = !s1_valid || s2_move;
  assign in_ready  = s1_move;
  assign fire      = in_valid && rnd_valid && s1_move;
  assign rnd_ready = fire;

  // S2 only captures a real beat; an empty S1 leaves a bubble.
  assign s2_load = s2_move && s1_valid;
`ifdef MSKAND_LANES_ZEROIZE_EN
  assign s2_clr  = s2_move && !s1_valid;
`else
  assign s2_clr  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prev  <= '0;
      s1_cur   <= '0;
      s1_rnd   <= '0;
    end else if (s1_move) begin
      s1_valid <= fire;
      if (fire) begin
        s1_prev <= prev_in;
        s1_cur  <= cur_in;
        s1_rnd  <= rnd;
      end
`ifdef MSKAND_LANES_ZEROIZE_EN
      else begin
        s1_prev <= '0;
        s1_cur  <= '0;
        s1_rnd  <= '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (s2_move) begin
      out_valid <= s1_valid;
    end
  end

  for (genvar l = 0; l < W; l++) begin : g_lane
    logic [d-1:0] lx;
    logic [d-1:0] ly;
    logic [d-1:0] lz;
    for (genvar s = 0; s < d; s++) begin : g_sh
      assign lx[s] = s1_prev[sh_idx(s, l, W)];
      assign ly[s] = s1_cur[sh_idx(s, l, W)];
      assign out_raw[sh_idx(s, l, W)] = lz[s];
    end
    mskand_hpc3_lane #(.d(d)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (s2_load),
      .clr  (s2_clr),
      .x    (lx),
      .y    (ly),
      .r    (s1_rnd[l*RL +: RL]),
      .z    (lz)
    );
  end

`ifdef MSKAND_LANES_ZEROIZE_EN
  assign out = out_valid ? out_raw : '0;
`else
  assign out = out_raw;
`endif

endmodule

// File: tb/tb_mskand_hpc3_lanes.sv
module tb_mskand_hpc3_lanes;
  localparam int D  = 2;
  localparam int W  = 4;
  localparam int RW = W * D * (D - 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [D*W-1:0]  in_a, in_b, out0, out1;
  logic            in_valid, rnd_valid, out_ready;
  logic [RW-1:0]   rnd;
  logic            in_ready0, in_ready1, rnd_ready0, rnd_ready1, out_valid0, out_valid1;

  int errors = 0;
  int checks = 0;

  // Reference: two occupancy slots holding plain (unmasked) results a&b.
  bit              m_s1v, m_ov;
  logic [W-1:0]    m_s1val, m_oval;
  logic [W-1:0]    cur_a, cur_b;
  int              rnd_hi, pops;
  logic [D*W-1:0]  held;

  always #5 clk = ~clk;

  mskand_hpc3_lanes #(.d(D), .W(W), .SWAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready0), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready0),
    .out(out0), .out_valid(out_valid0), .out_ready(out_ready));

  mskand_hpc3_lanes #(.d(D), .W(W), .SWAP(1)) dut1 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready1), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready1),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready));

  function automatic logic [W-1:0] rec(input logic [D*W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < D; s++) r ^= v[s*W +: W];
    return r;
  endfunction

  function automatic logic [D*W-1:0] split(input logic [W-1:0] v);
    logic [D*W-1:0] r;
    logic [W-1:0]   acc;
    acc = v;
    for (int s = 1; s < D; s++) begin
      r[s*W +: W] = W'($urandom);
      acc ^= r[s*W +: W];
    end
    r[W-1:0] = acc;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input bit iv, input bit rv, input bit ordy);
    cur_a     = va;
    cur_b     = vb;
    in_a      = split(va);
    in_b      = split(vb);
    rnd       = RW'($urandom);
    in_valid  = iv;
    rnd_valid = rv;
    out_ready = ordy;
  endtask

  task automatic reset_model();
    m_s1v = 0; m_ov = 0; m_s1val = '0; m_oval = '0;
  endtask

  // Checks outputs mid-cycle against the reference, then advances it by one edge.
  task automatic cycle();
    bit exp_rdy, exp_fire, s2m, s1m;
    @(negedge clk);
    exp_rdy  = !m_s1v || !m_ov || out_ready;
    exp_fire = in_valid && rnd_valid && exp_rdy;
    chk("in_ready",       in_ready0,  exp_rdy);
    chk("in_ready_swap",  in_ready1,  exp_rdy);
    chk("rnd_ready",      rnd_ready0, exp_fire);
    chk("rnd_ready_swap", rnd_ready1, exp_fire);
    chk("out_valid",      out_valid0, m_ov);
    chk("out_valid_swap", out_valid1, m_ov);
    if (m_ov) begin
      chk("out_data",      rec(out0), m_oval);
      chk("out_data_swap", rec(out1), m_oval);
    end else begin
`ifdef MSKAND_LANES_ZEROIZE_EN
      chk("idle_zero",      out0, 0);
      chk("idle_zero_swap", out1, 0);
`else
      chk("idle_stale",      rec(out0), m_oval);
      chk("idle_stale_swap", rec(out1), m_oval);
`endif
    end
    if (rnd_ready0) rnd_hi++;
    if (out_valid0 && out_ready) pops++;
    s2m = !m_ov || out_ready;
    s1m = !m_s1v || s2m;
    if (s2m) begin
      if (m_s1v) m_oval = m_s1val;
      m_ov = m_s1v;
    end
    if (s1m) begin
      m_s1v = exp_fire;
      if (exp_fire) m_s1val = cur_a & cur_b;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_rnd, base_pops;
    rst = 1'b1;
    reset_model();
    set_beat('0, '0, 0, 0, 1);
    rnd_hi = 0;
    pops   = 0;
    #3;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out",       out0, 0);
    chk("rst_in_ready",  in_ready0, 1);
    chk("rst_rnd_ready", rnd_ready0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single beat: latency and known value.
    set_beat(4'hF, 4'hA, 1, 1, 1);
    cycle();
    set_beat('0, '0, 0, 0, 1);
    chk("t1_lat_edge1", out_valid0, 0);
    cycle();
    chk("t1_lat_edge2", out_valid0, 1);
    chk("t1_value",     rec(out0), 4'hA);
    cycle();
    cycle();

    // Back-to-back stream of 8 beats.
    base_rnd  = rnd_hi;
    base_pops = pops;
    for (int i = 0; i < 8; i++) begin
      set_beat(W'($urandom), W'($urandom), 1, 1, 1);
      cycle();
    end
    set_beat('0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_rnd_ready_cycles", rnd_hi - base_rnd, 8);
    chk("t2_results",          pops - base_pops, 8);

    // Back-pressure with two beats in flight.
    set_beat(W'($urandom), W'($urandom), 1, 1, 1);
    cycle();
    set_beat(W'($urandom), W'($urandom), 1, 1, 0);
    cycle();
    held = out0;
    for (int i = 0; i < 5; i++) begin
      set_beat(W'($urandom), W'($urandom), 1, 1, 0);
      cycle();
      chk("t3_stall_in_ready", in_ready0, 0);
      chk("t3_stall_hold",     out0, held);
    end
    set_beat('0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle();

    // Data without randomness.
    set_beat(W'($urandom), W'($urandom), 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_no_rnd_accept", rnd_ready0, 0);
    rnd_valid = 1'b1;
    cycle();
    set_beat('0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset with beats in flight.
    set_beat(W'($urandom), W'($urandom), 1, 1, 1);
    cycle();
    set_beat(W'($urandom), W'($urandom), 1, 1, 1);
    cycle();
    set_beat('0, '0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_out_valid",      out_valid0, 0);
    chk("t5_async_out",            out0, 0);
    chk("t5_async_out_valid_swap", out_valid1, 0);
    chk("t5_async_out_swap",       out1, 0);
    reset_model();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    set_beat(W'($urandom), W'($urandom), 1, 1, 1);
    cycle();
    set_beat('0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic with random valids and back-pressure.
    for (int i = 0; i < 80; i++) begin
      set_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 2) != 0));
      cycle();
    end
    set_beat('0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
